// File: rtl/decode_stage_pipe.sv
// Registered decode stage with valid/ready handshake and a RAW/WAW scoreboard interlock.
// Define VEC_DECODE_EN to build vector-class decode and the vector-file scoreboard.
module decode_stage_pipe #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned IMM_W   = 18,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               wb_valid,
  input  logic               wb_vec,
  input  logic [REG_W-1:0]   wb_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [2:0]         out_alu_op,
  output logic               out_is_vec,
  output logic [REG_W-1:0]   out_rd,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic               out_rd_vec,
  output logic               out_rs1_vec,
  output logic               out_rs2_vec,
  output logic               out_we,
  output logic               out_use_imm,
  output logic               out_mem_rd,
  output logic               out_mem_wr,
  output logic               out_branch,
  output logic               out_illegal,
  output logic [DATA_W-1:0]  out_imm
);

  localparam int unsigned NREG    = 1 << REG_W;
  localparam int unsigned RD_LSB  = INSTR_W - OPC_W - REG_W;
  localparam int unsigned RS1_LSB = RD_LSB - REG_W;
  localparam int unsigned RS2_LSB = RS1_LSB - REG_W;

  // Instruction fields
  logic [OPC_W-1:0]  opc;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [IMM_W-1:0]  imm_raw;
  logic [DATA_W-1:0] imm_ext;
  logic [2:0]        cls;

  assign opc     = in_instr[INSTR_W-1 -: OPC_W];
  assign rd      = in_instr[RD_LSB +: REG_W];
  assign rs1     = in_instr[RS1_LSB +: REG_W];
  assign rs2     = in_instr[RS2_LSB +: REG_W];
  assign imm_raw = in_instr[IMM_W-1:0];
  assign imm_ext = DATA_W'($signed(imm_raw));
  assign cls     = {opc[OPC_W-1], opc[4:3]};

  // Decoded controls and which operand slots take part in hazard checks
  logic d_we;
  logic d_use_imm;
  logic d_mem_rd;
  logic d_mem_wr;
  logic d_branch;
  logic d_illegal;
  logic d_is_vec;
  logic d_rd_vec;
  logic d_rs1_vec;
  logic d_rs2_vec;
  logic use_rd;
  logic use_rs1;
  logic use_rs2;

  always_comb begin
    d_we      = 1'b0;
    d_use_imm = 1'b0;
    d_mem_rd  = 1'b0;
    d_mem_wr  = 1'b0;
    d_branch  = 1'b0;
    d_illegal = 1'b0;
    d_is_vec  = 1'b0;
    d_rd_vec  = 1'b0;
    d_rs1_vec = 1'b0;
    d_rs2_vec = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (cls)
      3'b000: begin
        d_we    = 1'b1;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      3'b001: begin
        d_we      = 1'b1;
        d_use_imm = 1'b1;
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
      end
      3'b010: begin
        d_we      = 1'b1;
        d_use_imm = 1'b1;
        d_mem_rd  = 1'b1;
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
      end
      3'b011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (opc[2]) begin
          d_branch = 1'b1;
        end else begin
          d_mem_wr  = 1'b1;
          d_use_imm = 1'b1;
        end
      end
`ifdef VEC_DECODE_EN
      3'b100: begin
        d_is_vec  = 1'b1;
        d_we      = 1'b1;
        d_rd_vec  = 1'b1;
        d_rs1_vec = 1'b1;
        d_rs2_vec = 1'b1;
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      3'b101: begin
        d_is_vec  = 1'b1;
        d_we      = 1'b1;
        d_rd_vec  = 1'b1;
        d_rs1_vec = 1'b1;
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      3'b110: begin
        d_is_vec = 1'b1;
        d_we     = 1'b1;
        d_rd_vec = 1'b1;
        d_mem_rd = 1'b1;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
      end
      3'b111: begin
        // vstore: vd is read as the store data, so it is a source here
        d_is_vec = 1'b1;
        d_rd_vec = 1'b1;
        d_mem_wr = 1'b1;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
      end
`endif
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  // Scoreboards: scalar file always, vector file only when vector decode is built
  logic [NREG-1:0] ssb;
  logic [NREG-1:0] s_set;
  logic [NREG-1:0] s_clr;
  logic            handoff;

  assign handoff = out_valid & out_ready & ~flush;

  always_comb begin
    s_set = '0;
    s_clr = '0;
    if (handoff & out_we & ~out_rd_vec & (out_rd != '0)) s_set[out_rd] = 1'b1;
    if (wb_valid & ~wb_vec) s_clr[wb_idx] = 1'b1;
  end

  // Set is OR-ed after the clear so a same-cycle set/clear leaves the bit pending
  always_ff @(posedge clk) begin
    if (rst) ssb <= '0;
    else     ssb <= (ssb & ~s_clr) | s_set;
  end

`ifdef VEC_DECODE_EN
  logic [NREG-1:0] vsb;
  logic [NREG-1:0] v_set;
  logic [NREG-1:0] v_clr;

  always_comb begin
    v_set = '0;
    v_clr = '0;
    if (handoff & out_we & out_rd_vec) v_set[out_rd] = 1'b1;
    if (wb_valid & wb_vec) v_clr[wb_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) vsb <= '0;
    else     vsb <= (vsb & ~v_clr) | v_set;
  end
`endif

  // Hazard: any used operand pending in its file or matching the held destination
  logic             hazard;
  logic             hit;
  logic [2:0]       op_use;
  logic [2:0]       op_vec;
  logic [REG_W-1:0] op_idx [3];

  assign op_use    = {use_rs2, use_rs1, use_rd};
  assign op_vec    = {d_rs2_vec, d_rs1_vec, d_rd_vec};
  assign op_idx[0] = rd;
  assign op_idx[1] = rs1;
  assign op_idx[2] = rs2;

  always_comb begin
    hazard = 1'b0;
    hit    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit = 1'b0;
      if (op_vec[i]) begin
`ifdef VEC_DECODE_EN
        hit = vsb[op_idx[i]] | (out_valid & out_we & out_rd_vec & (out_rd == op_idx[i]));
`endif
      end else if (op_idx[i] != '0) begin
        hit = ssb[op_idx[i]] | (out_valid & out_we & ~out_rd_vec & (out_rd == op_idx[i]));
      end
      hazard = hazard | (op_use[i] & hit);
    end
  end

  logic accept;

  assign in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Output register: flush kills the held bundle, otherwise load on accept or drain on ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_alu_op  <= '0;
      out_is_vec  <= 1'b0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd_vec  <= 1'b0;
      out_rs1_vec <= 1'b0;
      out_rs2_vec <= 1'b0;
      out_we      <= 1'b0;
      out_use_imm <= 1'b0;
      out_mem_rd  <= 1'b0;
      out_mem_wr  <= 1'b0;
      out_branch  <= 1'b0;
      out_illegal <= 1'b0;
      out_imm     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_alu_op  <= opc[2:0];
      out_is_vec  <= d_is_vec;
      out_rd      <= rd;
      out_rs1     <= rs1;
      out_rs2     <= rs2;
      out_rd_vec  <= d_rd_vec;
      out_rs1_vec <= d_rs1_vec;
      out_rs2_vec <= d_rs2_vec;
      out_we      <= d_we;
      out_use_imm <= d_use_imm;
      out_mem_rd  <= d_mem_rd;
      out_mem_wr  <= d_mem_wr;
      out_branch  <= d_branch;
      out_illegal <= d_illegal;
      out_imm     <= imm_ext;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
